// File: rtl/sclk_tone_gen.sv
// Square-wave speaker clock divider: MAXCOUNT is the half-period terminal count,
// retunes and stops are only honoured at half-period boundaries so SCLK never glitches.
module sclk_tone_gen #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] MAXCOUNT,
    input  logic             EN,
    output logic             SCLK,
    output logic             PERIOD_TICK,
    output logic             ACTIVE
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mc_q, mc_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             sclk_q, sclk_d;
    logic             tick_q, tick_d;
    logic             start;
    logic             stop;
    logic             boundary;

    assign start    = EN & (MAXCOUNT != '0);
    assign stop     = ~EN | (MAXCOUNT == '0);
    assign boundary = (count_q == mc_q);

    always_comb begin
        state_d = state_q;
        mc_d    = mc_q;
        count_d = count_q;
        sclk_d  = sclk_q;
        tick_d  = 1'b0;
        case (state_q)
            IDLE: begin
                count_d = '0;
                sclk_d  = 1'b0;
                if (start) begin
                    state_d = RUN;
                    mc_d    = MAXCOUNT;
                end
            end
            RUN: begin
                if (!boundary) begin
                    count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    count_d = '0;
                    // A stop seen at the boundary always lands low; a pending high half is never cut short.
                    if (stop) begin
                        sclk_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        sclk_d = ~sclk_q;
                        mc_d   = MAXCOUNT;
                        tick_d = ~sclk_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
                sclk_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            mc_q    <= '0;
            count_q <= '0;
            sclk_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mc_q    <= mc_d;
            count_q <= count_d;
            sclk_q  <= sclk_d;
            tick_q  <= tick_d;
        end
    end

    assign SCLK        = sclk_q;
    assign PERIOD_TICK = tick_q;
    assign ACTIVE      = (state_q == RUN);

endmodule

// File: tb/tb_sclk_tone_gen.sv
// Directed bench for sclk_tone_gen: per-cycle vector table plus hand sequences for
// async reset, and all-ones terminal counts on a 16-bit and an 8-bit instance.
module tb_sclk_tone_gen;

    logic        clk;
    logic        rst_n;
    logic [15:0] maxcount;
    logic        en;
    logic        sclk;
    logic        period_tick;
    logic        active;

    logic [7:0]  maxcount8;
    logic        en8;
    logic        sclk8;
    logic        period_tick8;
    logic        active8;

    int n_checks;
    int n_fail;

    typedef struct packed {
        logic        en;
        logic [15:0] mc;
        logic [2:0]  exp;  // {SCLK, PERIOD_TICK, ACTIVE} after the edge
    } vec_t;

    vec_t vq[$];

    sclk_tone_gen #(.WIDTH(16)) u_dut (
        .CLK         (clk),
        .RST_N       (rst_n),
        .MAXCOUNT    (maxcount),
        .EN          (en),
        .SCLK        (sclk),
        .PERIOD_TICK (period_tick),
        .ACTIVE      (active)
    );

    sclk_tone_gen #(.WIDTH(8)) u_dut8 (
        .CLK         (clk),
        .RST_N       (rst_n),
        .MAXCOUNT    (maxcount8),
        .EN          (en8),
        .SCLK        (sclk8),
        .PERIOD_TICK (period_tick8),
        .ACTIVE      (active8)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        en        = 1'b0;
        maxcount  = 16'h0;
        en8       = 1'b0;
        maxcount8 = 8'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic add(input logic e, input logic [15:0] m, input logic [2:0] x);
        vec_t v;
        v.en  = e;
        v.mc  = m;
        v.exp = x;
        vq.push_back(v);
    endtask

    initial begin
        int n;
        n_checks = 0;
        n_fail   = 0;

        // idle, silence, start, steady tone
        add(0, 16'h3, 3'b000); add(1, 16'h0, 3'b000); add(1, 16'h3, 3'b001);
        add(1, 16'h3, 3'b001); add(1, 16'h3, 3'b001); add(1, 16'h3, 3'b001);
        add(1, 16'h3, 3'b111); add(1, 16'h3, 3'b101); add(1, 16'h3, 3'b101);
        add(1, 16'h3, 3'b101); add(1, 16'h3, 3'b001); add(1, 16'h3, 3'b001);
        add(1, 16'h3, 3'b001); add(1, 16'h3, 3'b001); add(1, 16'h3, 3'b111);
        // retune 3 -> 1 two cycles after the rise
        add(1, 16'h3, 3'b101); add(1, 16'h1, 3'b101); add(1, 16'h1, 3'b101);
        add(1, 16'h1, 3'b001); add(1, 16'h1, 3'b001); add(1, 16'h1, 3'b111);
        add(1, 16'h1, 3'b101); add(1, 16'h1, 3'b001); add(1, 16'h1, 3'b001);
        add(1, 16'h1, 3'b111);
        // back to 3, then EN drops while high
        add(1, 16'h3, 3'b101); add(1, 16'h3, 3'b001); add(1, 16'h3, 3'b001);
        add(1, 16'h3, 3'b001); add(1, 16'h3, 3'b001); add(1, 16'h3, 3'b111);
        add(0, 16'h3, 3'b101); add(0, 16'h3, 3'b101); add(0, 16'h3, 3'b101);
        add(0, 16'h3, 3'b000); add(0, 16'h3, 3'b000);
        // EN drops while low
        add(1, 16'h3, 3'b001); add(0, 16'h3, 3'b001); add(0, 16'h3, 3'b001);
        add(0, 16'h3, 3'b001); add(0, 16'h3, 3'b000); add(0, 16'h3, 3'b000);
        // stop pulse between boundaries is ignored
        add(1, 16'h3, 3'b001); add(0, 16'h3, 3'b001); add(1, 16'h3, 3'b001);
        add(1, 16'h3, 3'b001); add(1, 16'h3, 3'b111);
        // silence code at a boundary acts as stop
        add(1, 16'h0, 3'b101); add(1, 16'h0, 3'b101); add(1, 16'h0, 3'b101);
        add(1, 16'h0, 3'b000); add(1, 16'h0, 3'b000);

        do_reset();
        check("reset_outputs", {29'd0, sclk, period_tick, active}, 32'd0);

        for (int i = 0; i < vq.size(); i++) begin
            en       = vq[i].en;
            maxcount = vq[i].mc;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec[%0d]", i), {29'd0, sclk, period_tick, active}, {29'd0, vq[i].exp});
        end

        // async reset mid-RUN, then restart latency
        do_reset();
        en       = 1'b1;
        maxcount = 16'h3;
        repeat (5) @(negedge clk);
        check("pre_reset_sclk", {31'd0, sclk}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", {29'd0, sclk, period_tick, active}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("restart_active", {29'd0, sclk, period_tick, active}, 32'b001);
        repeat (3) @(negedge clk);
        check("restart_k3", {29'd0, sclk, period_tick, active}, 32'b001);
        @(negedge clk);
        check("restart_k4", {29'd0, sclk, period_tick, active}, 32'b111);

        // 8-bit all-ones: 256-cycle low and high halves
        do_reset();
        en8       = 1'b1;
        maxcount8 = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        n = 0;
        while (sclk8 == 1'b0 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check("w8_low_half", n, 32'd256);
        check("w8_tick_at_rise", {31'd0, period_tick8}, 32'd1);
        n = 0;
        while (sclk8 == 1'b1 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check("w8_high_half", n, 32'd256);
        check("w8_active", {31'd0, active8}, 32'd1);

        // 16-bit all-ones: 65536-cycle half-period, no wrap
        do_reset();
        en       = 1'b1;
        maxcount = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        n = 0;
        while (sclk == 1'b0 && n < 70000) begin
            n++;
            @(negedge clk);
        end
        check("w16_low_half", n, 32'd65536);
        check("w16_tick_at_rise", {31'd0, period_tick}, 32'd1);
        @(negedge clk);
        check("w16_tick_one_cycle", {29'd0, sclk, period_tick, active}, 32'b101);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
